uart_tx_sched: RTL
==================

// Module: uart_tx_sched
// PURPOSE
//  Round-robin scheduler sharing one UART byte transmitter among NUM_REQ packet sources.
//  Grants one requester per packet (held until its last byte), feeds bytes one at a time.
//  Drives the transmitter's level-type send enable and byte bus; detects its done flag edge.
//  Inserts an idle gap between bytes and aborts a stuck byte or packet on timeout.
// PARAMETERS
//  NUM_REQ      2       number of requesters (2..8)
//  GAP_CYCLES   16      clocks of send_en low between bytes (>=1; the engine clears its counters then)
//  TIMEOUT_CYC  2000000 max clocks in SEND or LOAD before abort (> one 300-baud frame at 50 MHz)
// PORTS
//  clk          in   1          system clock (50 MHz)
//  rst_n        in   1          synchronous active-low reset
//  cfg_baud     in   3          baud code for the transmitter; sampled at packet start
//  req_valid    in   NUM_REQ    per requester: byte available
//  req_data     in   8*NUM_REQ  per requester byte; requester i uses [8i+7:8i]
//  req_last     in   NUM_REQ    per requester: this byte ends the packet
//  req_ready    out  NUM_REQ    combinational accept; one-hot or zero
//  tx_byte      out  8          byte to transmitter, held stable while tx_send_en=1
//  tx_baud      out  3          baud code to transmitter, constant for the whole packet
//  tx_send_en   out  1          transmitter enable (level)
//  tx_done      in   1          transmitter done flag (may stay high after send_en falls)
//  busy         out  1          high in any state except IDLE
//  grant_id     out  3          index of the current or last granted requester
//  pkt_done     out  1          1-cycle pulse: last byte of a packet completed
//  err_timeout  out  1          1-cycle pulse: timeout abort
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, tx_send_en=0, tx_byte=0, tx_baud=0, grant_id=0.
//   Also: rr pointer=0, done_q=0, timer=0, pkt_done=err_timeout=0.
//  done_q registers tx_done every cycle. done_rise = tx_done & ~done_q.
//  States:
//  IDLE: if |req_valid, pick the first valid requester scanning from rr_ptr upward (wraps).
//   Then: grant_id<=winner, tx_baud<=cfg_baud, timer<=0, go to LOAD. No req_ready in IDLE.
//  LOAD: req_ready[grant_id]=1 (all other bits 0).
//   If req_valid[grant_id], on that cycle: tx_byte<=data, last_q<=req_last, tx_send_en<=1,
//   timer<=0, go to SEND.
//   Otherwise wait; timer increments. Other requesters are ignored while the grant is held.
//  SEND: tx_send_en=1, timer increments.
//   On done_rise: tx_send_en<=0, gap_cnt<=0, go to GAP.
//   If last_q, also: pkt_done<=1 (one cycle), release grant, rr_ptr<=grant_id+1 (mod NUM_REQ).
//  GAP: tx_send_en=0 for exactly GAP_CYCLES clocks.
//   Then go to IDLE if the packet was released, else to LOAD.
//  Timeout: timer==TIMEOUT_CYC-1 in LOAD or SEND causes an abort:
//   tx_send_en<=0, err_timeout<=1 (one cycle), release grant, rr_ptr<=grant_id+1, go to GAP.
//   A timeout does not generate pkt_done.
//  done_rise outside SEND is ignored (stale done from the previous byte).
//  done_rise and timeout in the same cycle: done_rise wins, no error.
//  Single requester valid: it is regranted after GAP. The round-robin pointer prevents starvation.
//  Requester i sees exactly one req_ready&req_valid cycle per byte; data is captured that cycle.
//  Reset mid-byte: the outputs above are restored on the next clock; the partial byte is not resumed.
//  Byte latency: LOAD handshake -> tx_send_en rises the next cycle.
//  Packet release -> next grant decision in IDLE at GAP_CYCLES+1 clocks.
// TESTING (pair with the byte transmitter model, 115200 baud, GAP_CYCLES=16)
//  1. Req0 sends 3 bytes 0x55,0xA3,0x0F (last on 0x0F).
//     -> 3 send_en windows, tx_byte matches in order, one pkt_done after 0x0F, busy back to 0.
//  2. Req0 and Req1 both send 2-byte packets, valid in the same cycle after reset.
//     -> Req0 goes first. Req1 bytes are not interleaved. grant_id 0 then 1. Two pkt_done pulses.
//  3. Req0 repeatedly sends 1-byte packets while Req1 holds valid.
//     -> Grants alternate 0,1,0,1. No requester gets two consecutive grants while the other waits.
//  4. tx_done tied low, TIMEOUT_CYC=1000, Req1 sends 0x42.
//     -> send_en high for 1000 cycles, err_timeout pulse, no pkt_done, IDLE after 16-cycle gap.
//  5. Req0 drops valid mid-packet for 300 cycles, then resumes with 0x77 last.
//     -> Grant held, Req1 is not served meanwhile. 0x77 sent, then pkt_done.
//  6. rst_n low for 1 cycle while byte 2 of 3 is in SEND.
//     -> Next cycle: tx_send_en=0, busy=0, req_ready=0. Reset-state outputs verified.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART byte transmitter among NUM_REQ packet sources.
// A grant is held for a whole packet; bytes are separated by an idle gap and guarded by a timeout.
module uart_tx_sched #(
    parameter int NUM_REQ     = 2,
    parameter int GAP_CYCLES  = 16,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             cfg_baud,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_byte,
    output logic [2:0]             tx_baud,
    output logic                   tx_send_en,
    input  logic                   tx_done,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic                   pkt_done,
    output logic                   err_timeout
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t          state, state_nxt;
    logic            done_q, done_rise, last_q, rel_q;
    logic [TW-1:0]   timer;
    logic [GW-1:0]   gap_cnt;
    logic [2:0]      rr_ptr, rr_next, winner;
    logic [3:0]      idx_sum;
    logic            found, handshake, timeout;
    logic [7:0]      valid_ext, last_ext;
    logic [63:0]     data_ext;

    // Widen per-requester buses so a 3-bit index can select any requester.
    assign valid_ext = 8'(req_valid);
    assign last_ext  = 8'(req_last);
    assign data_ext  = 64'(req_data);

    assign done_rise = tx_done & ~done_q;
    assign handshake = (state == LOAD) && valid_ext[grant_id];
    assign timeout   = (timer == TMO_LAST);
    assign rr_next   = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
    assign busy      = (state != IDLE);
    assign req_ready = (state == LOAD) ? (NUM_REQ'(1) << grant_id) : '0;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        found   = 1'b0;
        winner  = rr_ptr;
        idx_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_sum = {1'b0, rr_ptr} + 4'(k);
            if (idx_sum >= 4'(NUM_REQ)) idx_sum = idx_sum - 4'(NUM_REQ);
            if (!found && valid_ext[idx_sum[2:0]]) begin
                found  = 1'b1;
                winner = idx_sum[2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (found) state_nxt = LOAD;
            LOAD: if (handshake || timeout) state_nxt = handshake ? SEND : GAP;
            SEND: if (done_rise || timeout) state_nxt = GAP;
            GAP:  if (gap_cnt == GAP_LAST) state_nxt = rel_q ? IDLE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            tx_send_en  <= 1'b0;
            tx_byte     <= 8'd0;
            tx_baud     <= 3'd0;
            grant_id    <= 3'd0;
            rr_ptr      <= 3'd0;
            timer       <= '0;
            gap_cnt     <= '0;
            last_q      <= 1'b0;
            rel_q       <= 1'b0;
            pkt_done    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done_q      <= tx_done;
            pkt_done    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    grant_id <= winner;
                    tx_baud  <= cfg_baud;
                    timer    <= '0;
                    rel_q    <= 1'b0;
                end
                LOAD: begin
                    if (handshake) begin
                        tx_byte    <= data_ext[{grant_id, 3'b000} +: 8];
                        last_q     <= last_ext[grant_id];
                        tx_send_en <= 1'b1;
                        timer      <= '0;
                    end else if (timeout) begin
                        err_timeout <= 1'b1;
                        rel_q       <= 1'b1;
                        rr_ptr      <= rr_next;
                        gap_cnt     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SEND: begin
                    // A done edge in the same cycle as the timeout still counts as success.
                    if (done_rise) begin
                        tx_send_en <= 1'b0;
                        gap_cnt    <= '0;
                        if (last_q) begin
                            pkt_done <= 1'b1;
                            rel_q    <= 1'b1;
                            rr_ptr   <= rr_next;
                        end
                    end else if (timeout) begin
                        tx_send_en  <= 1'b0;
                        err_timeout <= 1'b1;
                        rel_q       <= 1'b1;
                        rr_ptr      <= rr_next;
                        gap_cnt     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    timer   <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
